vga_timing_gen: RTL

Parametrised successor to the fixed 640x480 VGA sync generator. Produces horizontal and vertical sync, display-enable, pixel coordinates and line/frame start strobes for any timing mode set by parameters. Advances only on a pixel-clock enable, so one system clock can drive several pixel rates. Sits between the clock divider and the pixel/framebuffer pipeline; all outputs are registered.

---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_timing_axis.sv | 75 +++++++
 rtl/vga_timing_gen.sv | 96 +++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared phase type, default 640x480@60 timing and coordinate sizing helper
// for vga_timing_gen and its per-axis sub-module.
package vga_pkg;

    typedef enum logic [1:0] {DISPLAY, FRONT, SYNC, BACK} vga_phase_t;

    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    // Smallest width whose range 0..2^w-1 covers 0..total-1 (never below 1).
    function automatic int coord_bits(input int total);
        int b;
        b = 1;
        for (int i = 0; i < 30; i++)
            if ((1 << b) < total) b = b + 1;
        return b;
    endfunction

endpackage

// File: rtl/vga_timing_axis.sv
// One timing axis: phase FSM with a per-phase down-counter and a coordinate
// counter that wraps after the four phase lengths.
module vga_timing_axis
    import vga_pkg::*;
#(
    parameter int   DISPLAY_LEN = VGA_H_DISPLAY,
    parameter int   FRONT_LEN   = VGA_H_FRONT,
    parameter int   SYNC_LEN    = VGA_H_SYNC,
    parameter int   BACK_LEN    = VGA_H_BACK,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   COORD_BITS  = 10
) (
    input  logic                  clock_in,
    input  logic                  reset_n_in,
    input  logic                  step_in,
    output logic [COORD_BITS-1:0] coord_out,
    output vga_phase_t            phase_out,
    output logic                  sync_out,
    output logic                  wrap_out
);

    localparam int TOTAL = DISPLAY_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN;
    localparam logic [COORD_BITS-1:0] LAST = COORD_BITS'(TOTAL - 1);

    vga_phase_t            phase_q;
    logic [COORD_BITS-1:0] remain_q, remain_d, coord_d;

    function automatic logic [COORD_BITS-1:0] phase_len(input vga_phase_t p);
        case (p)
            DISPLAY: return COORD_BITS'(DISPLAY_LEN);
            FRONT:   return COORD_BITS'(FRONT_LEN);
            SYNC:    return COORD_BITS'(SYNC_LEN);
            default: return COORD_BITS'(BACK_LEN);
        endcase
    endfunction

    // phase_out is the phase after this edge, so the parent can register
    // decodes of it in step with the coordinate.
    always_comb begin
        phase_out = phase_q;
        remain_d  = remain_q;
        coord_d   = coord_out;
        wrap_out  = step_in && (coord_out == LAST);
        if (step_in) begin
            coord_d = wrap_out ? '0 : coord_out + 1'b1;
            if (remain_q == COORD_BITS'(1)) begin
                case (phase_q)
                    DISPLAY: phase_out = FRONT;
                    FRONT:   phase_out = SYNC;
                    SYNC:    phase_out = BACK;
                    default: phase_out = DISPLAY;
                endcase
                remain_d = phase_len(phase_out);
            end else begin
                remain_d = remain_q - 1'b1;
            end
        end
    end

    // Reset parks on the last back-porch position so the first step lands on 0.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            phase_q   <= BACK;
            remain_q  <= COORD_BITS'(1);
            coord_out <= LAST;
            sync_out  <= ~SYNC_ACTIVE;
        end else begin
            phase_q   <= phase_out;
            remain_q  <= remain_d;
            coord_out <= coord_d;
            sync_out  <= (phase_out == SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parameterised VGA sync/timing generator stepped by a pixel-clock enable.
// Optional frame counter port enabled by defining VGA_TIMING_FRAME_COUNT_EN.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_DISPLAY        = VGA_H_DISPLAY,
    parameter int   H_FRONT          = VGA_H_FRONT,
    parameter int   H_SYNC           = VGA_H_SYNC,
    parameter int   H_BACK           = VGA_H_BACK,
    parameter int   V_DISPLAY        = VGA_V_DISPLAY,
    parameter int   V_FRONT          = VGA_V_FRONT,
    parameter int   V_SYNC           = VGA_V_SYNC,
    parameter int   V_BACK           = VGA_V_BACK,
    parameter logic H_SYNC_ACTIVE    = 1'b0,
    parameter logic V_SYNC_ACTIVE    = 1'b0,
    parameter int   WIDTH_BITS       = 10,
    parameter int   HEIGHT_BITS      = 10,
    parameter int   FRAME_COUNT_BITS = 8
) (
    input  logic                        clock_in,
    input  logic                        reset_n_in,
    input  logic                        pixel_enable_in,
    output logic                        h_sync_out,
    output logic                        v_sync_out,
    output logic                        display_on_out,
    output logic [WIDTH_BITS-1:0]       pixel_x_out,
    output logic [HEIGHT_BITS-1:0]      pixel_y_out,
    output logic                        line_start_out,
    output logic                        frame_start_out
`ifdef VGA_TIMING_FRAME_COUNT_EN
    ,
    output logic [FRAME_COUNT_BITS-1:0] frame_count_out
`endif
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    generate
        if (H_DISPLAY == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
            V_DISPLAY == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0 ||
            WIDTH_BITS == 0 || HEIGHT_BITS == 0 || FRAME_COUNT_BITS == 0) begin : g_zero_param
            $error("vga_timing_gen: every timing/width parameter must be non-zero");
        end
        if (WIDTH_BITS < coord_bits(H_TOTAL) || HEIGHT_BITS < coord_bits(V_TOTAL)) begin : g_narrow
            $error("vga_timing_gen: coordinate width too small for the line/frame total");
        end
    endgenerate

    vga_phase_t h_phase, v_phase;
    logic       h_wrap, v_wrap, v_step;

    assign v_step = pixel_enable_in & h_wrap;

    vga_timing_axis #(
        .DISPLAY_LEN(H_DISPLAY), .FRONT_LEN(H_FRONT), .SYNC_LEN(H_SYNC), .BACK_LEN(H_BACK),
        .SYNC_ACTIVE(H_SYNC_ACTIVE), .COORD_BITS(WIDTH_BITS)
    ) u_h_axis (
        .clock_in(clock_in), .reset_n_in(reset_n_in), .step_in(pixel_enable_in),
        .coord_out(pixel_x_out), .phase_out(h_phase), .sync_out(h_sync_out), .wrap_out(h_wrap)
    );

    vga_timing_axis #(
        .DISPLAY_LEN(V_DISPLAY), .FRONT_LEN(V_FRONT), .SYNC_LEN(V_SYNC), .BACK_LEN(V_BACK),
        .SYNC_ACTIVE(V_SYNC_ACTIVE), .COORD_BITS(HEIGHT_BITS)
    ) u_v_axis (
        .clock_in(clock_in), .reset_n_in(reset_n_in), .step_in(v_step),
        .coord_out(pixel_y_out), .phase_out(v_phase), .sync_out(v_sync_out), .wrap_out(v_wrap)
    );

    // Strobes follow the wrap decodes directly, so they drop on any clock
    // that does not itself wrap.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            display_on_out  <= 1'b0;
            line_start_out  <= 1'b0;
            frame_start_out <= 1'b0;
        end else begin
            display_on_out  <= (h_phase == DISPLAY) && (v_phase == DISPLAY);
            line_start_out  <= h_wrap;
            frame_start_out <= h_wrap & v_wrap;
        end
    end

`ifdef VGA_TIMING_FRAME_COUNT_EN
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in)
            frame_count_out <= '0;
        else if (h_wrap & v_wrap)
            frame_count_out <= frame_count_out + 1'b1;
    end
`else
    // Frame counter absent in this build.
`endif

endmodule
